interrupt_controller: RTL and testbench

//  Requester side of the CPU interrupt handshake: drives INT, NMI and IntAddrLSBs into CPU, consumes INTACK.

---
 rtl/interrupt_controller.sv | 152 +++++++++++++++
 tb/tb_interrupt_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt requester: latches irq/nmi edges, arbitrates by fixed priority and runs the INT/NMI/INTACK handshake.
// Optional INTC_SYNC_EN: adds 2-flop input synchronisers ahead of edge detection.
module interrupt_controller #(
  parameter int unsigned NUM_SRC  = 16,
  parameter int unsigned BASE_VEC = 44,
  parameter int unsigned NMI_VEC  = 62,
  parameter int unsigned RST_VEC  = 63
) (
  input  logic               MCLK,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               nmi_req,
  input  logic               INTACK,
  output logic               INT,
  output logic               NMI,
  output logic [5:0]         IntAddrLSBs,
  output logic [NUM_SRC-1:0] pending
);

  localparam int unsigned SELW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    IDLE = 3'd1,
    IREQ = 3'd2,
    NREQ = 3'd3,
    ACKW = 3'd4
  } state_t;

  state_t             state;
  logic [SELW-1:0]    sel;
  logic               nmi_pend;
  logic [NUM_SRC-1:0] irq_in;
  logic               nmi_in;
  logic [NUM_SRC-1:0] irq_prev;
  logic               nmi_prev;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] irq_s1, irq_s2;
  logic               nmi_s1, nmi_s2;

  // Two-stage synchronisers for asynchronous request sources
  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
      nmi_s1 <= 1'b0;
      nmi_s2 <= 1'b0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
      nmi_s1 <= nmi_req;
      nmi_s2 <= nmi_s1;
    end
  end

  assign irq_in = irq_s2;
  assign nmi_in = nmi_s2;
`else
  assign irq_in = irq;
  assign nmi_in = nmi_req;
`endif

  logic [NUM_SRC-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_SRC-1:0] pend_clr;
  logic               nmi_clr;
  logic               req_any;
  logic [SELW-1:0]    req_idx;

  assign irq_rise = irq_in & ~irq_prev;
  assign nmi_rise = nmi_in & ~nmi_prev;
  assign pend_clr = (state == IREQ && INTACK) ? (NUM_SRC'(1) << sel) : '0;
  assign nmi_clr  = (state == NREQ) && INTACK;

  // Highest enabled pending index wins; later loop iterations override earlier ones
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && irq_en[i]) begin
        req_any = 1'b1;
        req_idx = SELW'(i);
      end
    end
  end

  // Pending flags, edge history and handshake FSM; a new edge beats a same-cycle clear
  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      sel         <= '0;
      INT         <= 1'b0;
      NMI         <= 1'b0;
      IntAddrLSBs <= 6'(RST_VEC);
      pending     <= '0;
      nmi_pend    <= 1'b0;
      irq_prev    <= '0;
      nmi_prev    <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      nmi_prev <= nmi_in;
      pending  <= (pending & ~pend_clr) | irq_rise;
      nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_rise;

      case (state)
        BOOT: begin
          INT         <= 1'b0;
          NMI         <= 1'b0;
          IntAddrLSBs <= 6'(RST_VEC);
          if (INTACK) state <= ACKW;
        end
        IDLE: begin
          if (nmi_pend) begin
            state       <= NREQ;
            NMI         <= 1'b1;
            IntAddrLSBs <= 6'(NMI_VEC);
          end else if (req_any) begin
            state       <= IREQ;
            INT         <= 1'b1;
            sel         <= req_idx;
            IntAddrLSBs <= 6'(BASE_VEC) + 6'(req_idx);
          end
        end
        IREQ: begin
          if (INTACK) begin
            INT   <= 1'b0;
            state <= ACKW;
          end
        end
        NREQ: begin
          if (INTACK) begin
            NMI   <= 1'b0;
            state <= ACKW;
          end
        end
        ACKW: begin
          INT <= 1'b0;
          NMI <= 1'b0;
          if (!INTACK) state <= IDLE;
        end
        default: begin
          state <= BOOT;
          INT   <= 1'b0;
          NMI   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (default parameters).
module tb_interrupt_controller;

`ifdef INTC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        MCLK = 1'b0;
  logic        rst;
  logic [15:0] irq;
  logic [15:0] irq_en;
  logic        nmi_req;
  logic        INTACK;
  logic        INT;
  logic        NMI;
  logic [5:0]  IntAddrLSBs;
  logic [15:0] pending;

  int checks = 0;
  int passed = 0;

  interrupt_controller dut (
    .MCLK        (MCLK),
    .rst         (rst),
    .irq         (irq),
    .irq_en      (irq_en),
    .nmi_req     (nmi_req),
    .INTACK      (INTACK),
    .INT         (INT),
    .NMI         (NMI),
    .IntAddrLSBs (IntAddrLSBs),
    .pending     (pending)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; irq = '0; irq_en = '0; nmi_req = 1'b0; INTACK = 1'b0;

    // reset and boot handshake
    tick(3);
    check("rst_int",  32'(INT), 32'd0);
    check("rst_nmi",  32'(NMI), 32'd0);
    check("rst_vec",  32'(IntAddrLSBs), 32'd63);
    check("rst_pend", 32'(pending), 32'd0);
    rst = 1'b0;
    tick(1);
    check("boot_vec", 32'(IntAddrLSBs), 32'd63);
    check("boot_int", 32'(INT), 32'd0);
    INTACK = 1'b1;
    tick(1);
    check("ackw_vec", 32'(IntAddrLSBs), 32'd63);
    check("ackw_int", 32'(INT), 32'd0);
    INTACK = 1'b0;
    tick(1);
    check("idle_vec", 32'(IntAddrLSBs), 32'd63);
    check("idle_int", 32'(INT), 32'd0);

    // single source, latency and level hold
    irq_en = 16'h0002; irq = 16'h0002;
    tick(LAT - 1);
    check("t2_pend",      32'(pending), 32'h0002);
    check("t2_int_early", 32'(INT), 32'd0);
    tick(1);
    check("t2_int", 32'(INT), 32'd1);
    check("t2_vec", 32'(IntAddrLSBs), 32'd45);
    check("t2_nmi", 32'(NMI), 32'd0);
    tick(2);
    check("t2_hold_int", 32'(INT), 32'd1);
    check("t2_hold_vec", 32'(IntAddrLSBs), 32'd45);
    INTACK = 1'b1;
    tick(1);
    check("t2_ack_int",  32'(INT), 32'd0);
    check("t2_ack_pend", 32'(pending), 32'h0000);
    INTACK = 1'b0;
    tick(2);
    check("t2_level_int",  32'(INT), 32'd0);
    check("t2_level_pend", 32'(pending), 32'h0000);
    irq = '0;
    tick(4);

    // simultaneous edges, descending service order
    irq_en = 16'hFFFF; irq = 16'h0021;
    tick(LAT - 1);
    check("t3_pend", 32'(pending), 32'h0021);
    tick(1);
    check("t3_int1", 32'(INT), 32'd1);
    check("t3_vec1", 32'(IntAddrLSBs), 32'd49);
    INTACK = 1'b1;
    tick(1);
    check("t3_ack_int",  32'(INT), 32'd0);
    check("t3_ack_pend", 32'(pending), 32'h0001);
    INTACK = 1'b0;
    tick(1);
    check("t3_gap_int", 32'(INT), 32'd0);
    tick(1);
    check("t3_int2", 32'(INT), 32'd1);
    check("t3_vec2", 32'(IntAddrLSBs), 32'd44);
    INTACK = 1'b1;
    tick(1);
    check("t3_ack2_pend", 32'(pending), 32'h0000);
    INTACK = 1'b0;
    irq = '0;
    tick(4);

    // nmi arriving during an outstanding maskable request
    irq = 16'h0002;
    tick(LAT);
    check("t4_int", 32'(INT), 32'd1);
    check("t4_vec", 32'(IntAddrLSBs), 32'd45);
    nmi_req = 1'b1;
    tick(4);
    check("t4_hold_int", 32'(INT), 32'd1);
    check("t4_hold_vec", 32'(IntAddrLSBs), 32'd45);
    check("t4_hold_nmi", 32'(NMI), 32'd0);
    INTACK = 1'b1;
    tick(1);
    check("t4_ack_int", 32'(INT), 32'd0);
    check("t4_ack_nmi", 32'(NMI), 32'd0);
    INTACK = 1'b0;
    tick(2);
    check("t4_nmi",     32'(NMI), 32'd1);
    check("t4_nmi_vec", 32'(IntAddrLSBs), 32'd62);
    check("t4_nmi_int", 32'(INT), 32'd0);
    INTACK = 1'b1;
    tick(1);
    check("t4_nack", 32'(NMI), 32'd0);
    INTACK = 1'b0; nmi_req = 1'b0; irq = '0;
    tick(4);
    check("t4_idle_nmi", 32'(NMI), 32'd0);

    // new edge on the selected source coincides with INTACK: set wins
    irq = 16'h0004;
    tick(LAT);
    check("sw_int", 32'(INT), 32'd1);
    check("sw_vec", 32'(IntAddrLSBs), 32'd46);
    irq = '0;
    tick(4);
    check("sw_hold_int", 32'(INT), 32'd1);
    irq = 16'h0004;
    tick(LAT - 2);
    INTACK = 1'b1;
    tick(1);
    check("sw_ack_int",  32'(INT), 32'd0);
    check("sw_ack_pend", 32'(pending), 32'h0004);
    INTACK = 1'b0;
    tick(2);
    check("sw_int2", 32'(INT), 32'd1);
    check("sw_vec2", 32'(IntAddrLSBs), 32'd46);
    INTACK = 1'b1;
    tick(1);
    check("sw_ack2_pend", 32'(pending), 32'h0000);
    INTACK = 1'b0;
    irq = '0;
    tick(4);

    // disabled source stays pending until enabled
    irq_en = 16'hFFF7; irq = 16'h0008;
    tick(LAT + 2);
    check("t5_pend", 32'(pending), 32'h0008);
    check("t5_int",  32'(INT), 32'd0);
    irq_en = 16'hFFFF;
    tick(1);
    check("t5_en_int", 32'(INT), 32'd1);
    check("t5_en_vec", 32'(IntAddrLSBs), 32'd47);
    INTACK = 1'b1;
    tick(1);
    INTACK = 1'b0;
    irq = '0;
    tick(4);

    // async reset in the middle of a request
    irq = 16'h0002;
    tick(LAT);
    check("t6_int", 32'(INT), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_int",  32'(INT), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'h0000);
    check("t6_rst_vec",  32'(IntAddrLSBs), 32'd63);
    irq = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t6_boot_vec", 32'(IntAddrLSBs), 32'd63);
    check("t6_boot_int", 32'(INT), 32'd0);
    INTACK = 1'b1;
    tick(1);
    INTACK = 1'b0;
    tick(2);
    check("t6_idle_int",  32'(INT), 32'd0);
    check("t6_idle_pend", 32'(pending), 32'h0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
